// File: rtl/esa_pkg.sv
// Shared types and constants for the key-locked equal segmentation adder pipeline.
// The payload is sized from the package widths, so the top-level parameters must match them.
package esa_pkg;

    localparam int unsigned ESA_WIDTH = 32;
    localparam int unsigned ESA_SEG_W = 8;
    localparam int unsigned ESA_KEY_W = 64;
    localparam logic [ESA_KEY_W-1:0] ESA_CORRECT_KEY = 64'h0CA62A6BA0D1A712;

    localparam int unsigned NSEG        = ESA_WIDTH / ESA_SEG_W;
    localparam int unsigned MASK_CHUNKS = (ESA_KEY_W + ESA_WIDTH) / (ESA_WIDTH + 1);

    typedef struct packed {
        logic                 valid;
        logic                 mode;
        logic                 carry;
        logic [ESA_WIDTH-1:0] sum_lo;
        logic [ESA_WIDTH-1:0] a_hi;
        logic [ESA_WIDTH-1:0] b_hi;
    } esa_payload_t;

    // XOR-fold the key difference into a result-wide mask; zero when the key matches.
    function automatic logic [ESA_WIDTH:0] fold_key_mask(input logic [ESA_KEY_W-1:0] d);
        logic [MASK_CHUNKS*(ESA_WIDTH+1)-1:0] ext;
        logic [ESA_WIDTH:0]                   m;
        ext                = '0;
        ext[ESA_KEY_W-1:0] = d;
        m                  = '0;
        for (int unsigned c = 0; c < MASK_CHUNKS; c++) begin
            m ^= ext[c*(ESA_WIDTH+1) +: ESA_WIDTH+1];
        end
        return m;
    endfunction

endpackage

// File: rtl/esa_segment_stage.sv
// One pipeline stage: adds the lowest pending operand segment and writes it into sum slot IDX.
// Exact mode chains the previous stage's carry; approximate mode forces carry-in to zero.
module esa_segment_stage
    import esa_pkg::*;
#(
    parameter int unsigned SEG_W = ESA_SEG_W,
    parameter int unsigned IDX   = 0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  esa_payload_t i_p,
    output esa_payload_t o_p
);

    logic [SEG_W:0] w_seg_sum;
    logic           w_cin;
    esa_payload_t   w_next;
    esa_payload_t   r_p;

    always_comb begin
        w_cin     = i_p.mode & i_p.carry;
        w_seg_sum = {1'b0, i_p.a_hi[SEG_W-1:0]} + {1'b0, i_p.b_hi[SEG_W-1:0]}
                  + {{SEG_W{1'b0}}, w_cin};
        w_next                             = i_p;
        w_next.carry                       = w_seg_sum[SEG_W];
        w_next.sum_lo[IDX*SEG_W +: SEG_W]  = w_seg_sum[SEG_W-1:0];
        w_next.a_hi                        = i_p.a_hi >> SEG_W;
        w_next.b_hi                        = i_p.b_hi >> SEG_W;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= w_next;
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/equal_segmentation_adder_pipe.sv
// Pipelined key-locked equal segmentation adder: one segment per stage, global stall,
// key-derived XOR mask applied as the sum enters the output register.
module equal_segmentation_adder_pipe
    import esa_pkg::*;
#(
    parameter int unsigned       WIDTH       = ESA_WIDTH,
    parameter int unsigned       SEG_W       = ESA_SEG_W,
    parameter int unsigned       KEY_W       = ESA_KEY_W,
    parameter logic [KEY_W-1:0]  CORRECT_KEY = ESA_CORRECT_KEY
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic             mode_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [KEY_W-1:0] keyinput,
    input  logic             key_load_i,
    output logic             busy_o,
    output logic [WIDTH:0]   result_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    esa_payload_t     w_pipe [NSEG+1];
    logic             w_adv;
    logic             w_busy;
    logic [WIDTH:0]   w_mask;
    logic [WIDTH:0]   w_raw_sum;
    logic [KEY_W-1:0] r_key;
    logic             r_out_valid;
    logic [WIDTH:0]   r_result;

    assign w_adv      = !r_out_valid || out_ready_i;
    assign in_ready_o = w_adv;

    // Stage 0 loads on w_adv, so its valid bit is exactly the input handshake.
    assign w_pipe[0] = '{valid: in_valid_i, mode: mode_i, carry: 1'b0,
                         sum_lo: '0, a_hi: add1_i, b_hi: add2_i};

    for (genvar g = 0; g < NSEG; g++) begin : g_stage
        esa_segment_stage #(
            .SEG_W(SEG_W),
            .IDX  (g)
        ) u_stage (
            .i_clk(clk_i),
            .i_rst(rst_i),
            .i_en (w_adv),
            .i_p  (w_pipe[g]),
            .o_p  (w_pipe[g+1])
        );
    end

    always_comb begin
        w_busy = 1'b0;
        for (int unsigned i = 1; i <= NSEG; i++) begin
            w_busy |= w_pipe[i].valid;
        end
    end

    assign w_mask    = fold_key_mask(r_key ^ CORRECT_KEY);
    assign w_raw_sum = {w_pipe[NSEG].carry, w_pipe[NSEG].sum_lo};

    // Loads only with an empty pipeline and no offered operand, so in-flight sums never see a key change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_key <= '0;
        end else if (key_load_i && !w_busy && !in_valid_i) begin
            r_key <= keyinput;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_adv) begin
            r_out_valid <= w_pipe[NSEG].valid;
            r_result    <= w_raw_sum ^ w_mask;
        end
    end

    assign busy_o      = w_busy;
    assign result_o    = r_result;
    assign out_valid_o = r_out_valid;

endmodule

// File: tb/tb_equal_segmentation_adder_pipe.sv
// Directed self-checking bench for equal_segmentation_adder_pipe (32-bit, 8-bit segments).
module tb_equal_segmentation_adder_pipe;

    localparam logic [63:0] CK          = 64'h0CA62A6BA0D1A712;
    localparam logic [32:0] LOCKED_MASK = 33'h1_A682_B227;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] add1_i = '0;
    logic [31:0] add2_i = '0;
    logic        mode_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [63:0] keyinput = '0;
    logic        key_load_i = 1'b0;
    logic        busy_o;
    logic [32:0] result_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n;

    logic [31:0] va [8] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678,
                            32'h000000FF, 32'h000000FF, 32'h80000000, 32'h00FF00FF};
    logic [31:0] vb [8] = '{32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h11111111,
                            32'h00000001, 32'h00000001, 32'h80000000, 32'h00010001};
    logic        vm [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [32:0] ve [8] = '{33'h0_00000002, 33'h1_FFFFFFFE, 33'h1_FEFEFEFE, 33'h0_23456789,
                            33'h0_00000000, 33'h0_00000100, 33'h1_00000000, 33'h0_01000100};

    always #5 clk = ~clk;

    equal_segmentation_adder_pipe #(
        .WIDTH      (32),
        .SEG_W      (8),
        .KEY_W      (64),
        .CORRECT_KEY(CK)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .add1_i     (add1_i),
        .add2_i     (add2_i),
        .mode_i     (mode_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .keyinput   (keyinput),
        .key_load_i (key_load_i),
        .busy_o     (busy_o),
        .result_o   (result_o),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [63:0] k);
        keyinput   = k;
        key_load_i = 1'b1;
        tick();
        key_load_i = 1'b0;
    endtask

    task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic m, input logic [32:0] exp, input logic kl);
        int unsigned cnt;
        add1_i     = a;
        add2_i     = b;
        mode_i     = m;
        in_valid_i = 1'b1;
        key_load_i = kl;
        tick();
        in_valid_i = 1'b0;
        key_load_i = 1'b0;
        cnt = 0;
        while (!out_valid_o && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, "_lat"}, 64'(cnt), 64'd4);
        chk(tag, 64'(result_o), 64'(exp));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        rst_i = 1'b0;
        chk("rst_out_valid", 64'(out_valid_o), 64'd0);
        chk("rst_result",    64'(result_o),    64'd0);
        chk("rst_busy",      64'(busy_o),      64'd0);
        chk("rst_in_ready",  64'(in_ready_o),  64'd1);

        run_one("locked_zero", 32'h0, 32'h0, 1'b1, LOCKED_MASK, 1'b0);

        load_key(CK);
        run_one("exact_wrap",  32'hFFFFFFFF, 32'h00000001, 1'b1, 33'h1_00000000, 1'b0);
        run_one("approx_wrap", 32'hFFFFFFFF, 32'h00000001, 1'b0, 33'h0_FFFFFF00, 1'b0);

        load_key(CK ^ 64'h1);
        run_one("wrong_key", 32'h29AF2430, 32'h7A1B9ABC, 1'b1, 33'h0_A3CABEED, 1'b0);

        load_key(CK);
        fork
            begin : driver
                int unsigned i = 0;
                int unsigned guard = 0;
                while (i < 8 && guard < 60) begin
                    add1_i     = va[i];
                    add2_i     = vb[i];
                    mode_i     = vm[i];
                    in_valid_i = 1'b1;
                    #3;
                    if (in_ready_o) i++;
                    @(posedge clk);
                    #1;
                    guard++;
                end
                in_valid_i = 1'b0;
                chk("stream_sent", 64'(i), 64'd8);
            end
            begin : collector
                int unsigned got = 0;
                int unsigned cyc = 0;
                while (got < 8 && cyc < 60) begin
                    out_ready_i = !(cyc >= 6 && cyc <= 8);
                    #3;
                    if (out_valid_o) begin
                        if (out_ready_i) begin
                            chk($sformatf("stream_%0d", got), 64'(result_o), 64'(ve[got]));
                            got++;
                        end else begin
                            chk($sformatf("stall_hold_%0d", cyc), 64'(result_o), 64'(ve[got]));
                            chk($sformatf("stall_in_ready_%0d", cyc), 64'(in_ready_o), 64'd0);
                        end
                    end
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                out_ready_i = 1'b1;
                chk("stream_count", 64'(got), 64'd8);
            end
        join
        tick();
        chk("stream_idle", 64'(busy_o | out_valid_o), 64'd0);

        add1_i     = 32'h29AF2430;
        add2_i     = 32'h7A1B9ABC;
        mode_i     = 1'b1;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        chk("busy_in_flight", 64'(busy_o), 64'd1);
        load_key(CK ^ 64'hFF);
        n = 0;
        while (!out_valid_o && n < 20) begin
            tick();
            n++;
        end
        chk("busy_load_lat", 64'(n), 64'd3);
        chk("busy_load_result", 64'(result_o), 64'h0_A3CABEEC);
        tick();
        run_one("load_with_valid", 32'h000000FF, 32'h00000001, 1'b1, 33'h0_00000100, 1'b1);
        run_one("key_kept",        32'h12345678, 32'h11111111, 1'b1, 33'h0_23456789, 1'b0);

        mode_i     = 1'b1;
        in_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            add1_i = 32'h11111111 * (k + 1);
            add2_i = 32'h01010101;
            tick();
        end
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("midrst_out_valid", 64'(out_valid_o), 64'd0);
        chk("midrst_busy",      64'(busy_o),      64'd0);
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (out_valid_o) n++;
            tick();
        end
        chk("midrst_no_stale", 64'(n), 64'd0);
        run_one("midrst_locked", 32'h0, 32'h0, 1'b1, LOCKED_MASK, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
